drink_vend_ctrl: RTL and testbench

Sequencing controller for the drink machine datapath. Accumulates coin credit, grants a one-hot dispense enable to one of four drink slots when credit covers the price, and returns change or refunds as serial nickel pulses. Sits between the coin acceptor and the slot read-enable / nickel-return drivers inside the drink machine top level.

---
 rtl/drink_vend_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_drink_vend_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drink_vend_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : drink_vend_ctrl
// Description : Drink machine sequencing controller. Accumulates coin credit,
//               grants a one-hot slot dispense enable when credit covers the
//               price, and returns change/refunds as serial nickel pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module drink_vend_ctrl #(
    parameter int PRICE       = 7,
    parameter int CREDIT_W    = 6,
    parameter int MAX_CREDIT  = 40,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                nickel_in,
    input  logic                dime_in,
    input  logic                quarter_in,
    input  logic                cancel,
    input  logic [3:0]          drink_sel,
    input  logic [3:0]          slot_empty,
    input  logic                dispense_ack,
    output logic [3:0]          slot_en,
    output logic                nickel_out,
    output logic                coin_reject,
    output logic                sel_denied,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [CREDIT_W-1:0] C_PRICE    = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W:0]   C_MAX      = (CREDIT_W + 1)'(MAX_CREDIT);
    localparam logic [CNT_W-1:0]    C_CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COLLECT  = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_t;

    state_t              state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic [3:0]          slot_en_q;
    logic                nickel_out_q;
    logic                coin_reject_q;
    logic                sel_denied_q;
    logic                busy_q;
    logic [CNT_W-1:0]    cnt_q;

    // Coin value of this cycle in nickels (max 8), widened to compare against the ceiling
    logic [3:0]          w_coin_sum4;
    logic [CREDIT_W:0]   w_coin_sum;
    logic [CREDIT_W:0]   w_credit_sum;
    logic                w_coin_any;
    logic                w_coin_fits;
    logic                w_sel_any;
    logic                w_sel_ok;

    assign w_coin_sum4  = {3'b000, nickel_in} + {2'b00, dime_in, 1'b0} + {1'b0, quarter_in, 1'b0, quarter_in};
    assign w_coin_sum   = {{(CREDIT_W - 3){1'b0}}, w_coin_sum4};
    assign w_credit_sum = {1'b0, credit_q} + w_coin_sum;
    assign w_coin_any   = nickel_in | dime_in | quarter_in;
    assign w_coin_fits  = (w_credit_sum <= C_MAX);
    assign w_sel_any    = |drink_sel;
    assign w_sel_ok     = $onehot(drink_sel) && ((drink_sel & slot_empty) == 4'b0000)
                          && (credit_q >= C_PRICE);

    // Main controller: state, credit, dispense timer and all registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            credit_q      <= '0;
            slot_en_q     <= 4'b0000;
            nickel_out_q  <= 1'b0;
            coin_reject_q <= 1'b0;
            sel_denied_q  <= 1'b0;
            busy_q        <= 1'b0;
            cnt_q         <= '0;
        end else begin
            nickel_out_q  <= 1'b0;
            coin_reject_q <= 1'b0;
            sel_denied_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Cancel is meaningless with no credit; selections are refused
                    if (w_sel_any) begin
                        sel_denied_q <= 1'b1;
                    end
                    if (w_coin_any) begin
                        if (w_coin_fits) begin
                            credit_q <= w_credit_sum[CREDIT_W-1:0];
                            state_q  <= S_COLLECT;
                        end else begin
                            coin_reject_q <= 1'b1;
                        end
                    end
                end
                S_COLLECT: begin
                    if (cancel) begin
                        coin_reject_q <= w_coin_any;
                        state_q       <= S_CHANGE;
                        busy_q        <= 1'b1;
                    end else if (w_sel_ok) begin
                        coin_reject_q <= w_coin_any;
                        slot_en_q     <= drink_sel;
                        credit_q      <= credit_q - C_PRICE;
                        cnt_q         <= '0;
                        state_q       <= S_DISPENSE;
                        busy_q        <= 1'b1;
                    end else begin
                        if (w_sel_any) begin
                            sel_denied_q <= 1'b1;
                        end
                        if (w_coin_any) begin
                            if (w_coin_fits) begin
                                credit_q <= w_credit_sum[CREDIT_W-1:0];
                            end else begin
                                coin_reject_q <= 1'b1;
                            end
                        end
                    end
                end
                S_DISPENSE: begin
                    coin_reject_q <= w_coin_any;
                    // An ack arriving on the final timeout cycle still wins
                    if (dispense_ack) begin
                        slot_en_q <= 4'b0000;
                        if (credit_q != '0) begin
                            state_q <= S_CHANGE;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else if (cnt_q == C_CNT_LAST) begin
                        // Abort: give the price back and refund everything
                        slot_en_q <= 4'b0000;
                        credit_q  <= credit_q + C_PRICE;
                        state_q   <= S_CHANGE;
                        busy_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_CHANGE: begin
                    coin_reject_q <= w_coin_any;
                    // Pulses alternate with gap cycles; leave after the last pulse
                    if (nickel_out_q) begin
                        if (credit_q == '0) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else if (credit_q != '0) begin
                        nickel_out_q <= 1'b1;
                        credit_q     <= credit_q - 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign slot_en     = slot_en_q;
    assign nickel_out  = nickel_out_q;
    assign coin_reject = coin_reject_q;
    assign sel_denied  = sel_denied_q;
    assign busy        = busy_q;
    assign credit      = credit_q;

endmodule
`default_nettype wire

// File: tb/tb_drink_vend_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_drink_vend_ctrl
// Description : Self-checking bench for drink_vend_ctrl. Directed scenarios
//               plus biased random traffic, compared every cycle against a
//               schedule-based reference model of the vending rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_drink_vend_ctrl;

    localparam int PRICE       = 7;
    localparam int CREDIT_W    = 6;
    localparam int MAX_CREDIT  = 40;
    localparam int ACK_TIMEOUT = 8;

    localparam int M_IDLE     = 0;
    localparam int M_COLLECT  = 1;
    localparam int M_DISPENSE = 2;
    localparam int M_CHANGE   = 3;

    logic                clk;
    logic                reset;
    logic                nickel_in;
    logic                dime_in;
    logic                quarter_in;
    logic                cancel;
    logic [3:0]          drink_sel;
    logic [3:0]          slot_empty;
    logic                dispense_ack;
    logic [3:0]          slot_en;
    logic                nickel_out;
    logic                coin_reject;
    logic                sel_denied;
    logic                busy;
    logic [CREDIT_W-1:0] credit;

    int n_checks;
    int n_errors;

    // Reference model state
    int m_mode;
    int m_credit;
    int m_slot;
    int m_nk;
    int m_rej;
    int m_den;
    int m_waited;
    int m_sched[$];

    drink_vend_ctrl #(
        .PRICE       (PRICE),
        .CREDIT_W    (CREDIT_W),
        .MAX_CREDIT  (MAX_CREDIT),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .nickel_in    (nickel_in),
        .dime_in      (dime_in),
        .quarter_in   (quarter_in),
        .cancel       (cancel),
        .drink_sel    (drink_sel),
        .slot_empty   (slot_empty),
        .dispense_ack (dispense_ack),
        .slot_en      (slot_en),
        .nickel_out   (nickel_out),
        .coin_reject  (coin_reject),
        .sel_denied   (sel_denied),
        .busy         (busy),
        .credit       (credit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_credit = 0;
        m_slot   = 0;
        m_nk     = 0;
        m_rej    = 0;
        m_den    = 0;
        m_waited = 0;
        m_sched.delete();
    endtask

    // Refund of N nickels: N pulses separated by single gap cycles
    task automatic start_change();
        m_mode = M_CHANGE;
        m_sched.delete();
        for (int i = 0; i < m_credit; i++) begin
            if (i > 0) m_sched.push_back(0);
            m_sched.push_back(1);
        end
    endtask

    task automatic model_step();
        int sum;
        bit valid;
        sum   = int'(nickel_in) + 2 * int'(dime_in) + 5 * int'(quarter_in);
        m_nk  = 0;
        m_rej = 0;
        m_den = 0;
        case (m_mode)
            M_IDLE, M_COLLECT: begin
                valid = ($countones(drink_sel) == 1) && ((drink_sel & slot_empty) == 4'b0)
                        && (m_credit >= PRICE);
                if (m_mode == M_COLLECT && cancel) begin
                    m_rej = (sum > 0);
                    start_change();
                end else if (m_mode == M_COLLECT && valid) begin
                    m_rej    = (sum > 0);
                    m_slot   = int'(drink_sel);
                    m_credit = m_credit - PRICE;
                    m_waited = 0;
                    m_mode   = M_DISPENSE;
                end else begin
                    m_den = (drink_sel != 4'b0);
                    if (sum > 0) begin
                        if (m_credit + sum <= MAX_CREDIT) begin
                            m_credit = m_credit + sum;
                            m_mode   = M_COLLECT;
                        end else begin
                            m_rej = 1;
                        end
                    end
                end
            end
            M_DISPENSE: begin
                m_rej = (sum > 0);
                m_waited++;
                if (dispense_ack) begin
                    m_slot = 0;
                    if (m_credit > 0) start_change();
                    else m_mode = M_IDLE;
                end else if (m_waited == ACK_TIMEOUT) begin
                    m_slot   = 0;
                    m_credit = m_credit + PRICE;
                    start_change();
                end
            end
            default: begin
                m_rej = (sum > 0);
                if (m_sched.size() == 0) begin
                    m_mode = M_IDLE;
                end else begin
                    m_nk = m_sched.pop_front();
                    if (m_nk == 1) m_credit--;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check_val("slot_en", int'(slot_en), m_slot);
        check_val("nickel_out", int'(nickel_out), m_nk);
        check_val("coin_reject", int'(coin_reject), m_rej);
        check_val("sel_denied", int'(sel_denied), m_den);
        check_val("busy", int'(busy), (m_mode == M_DISPENSE || m_mode == M_CHANGE) ? 1 : 0);
        check_val("credit", int'(credit), m_credit);
    endtask

    // Inputs are already set (at a negedge); advance one clock and check
    task automatic cycle();
        @(posedge clk);
        if (reset) model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input logic n, input logic d, input logic q, input logic c,
                         input logic [3:0] sel, input logic [3:0] emp, input logic ack);
        nickel_in    = n;
        dime_in      = d;
        quarter_in   = q;
        cancel       = c;
        drink_sel    = sel;
        slot_empty   = emp;
        dispense_ack = ack;
        cycle();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) drive(0, 0, 0, 0, 4'b0, 4'b0, 0);
    endtask

    // Async reset asserted mid-cycle, held across one rising edge
    task automatic reset_pulse();
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        drive(0, 0, 0, 0, 4'b0, 4'b0, 0);
        reset = 1'b1;
    endtask

    int p_coin[6]   = '{30, 40, 20, 50, 60, 25};
    int p_sel[6]    = '{10,  0, 20,  5,  0, 30};
    int p_cancel[6] = '{ 2,  0,  5,  1,  1,  3};
    int p_ack[6]    = '{30, 20,  5, 50, 10, 15};
    int p_empty[6]  = '{20,  0, 30, 50,  0, 10};

    initial begin
        logic [3:0] sel;
        logic [3:0] emp;
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        nickel_in = 0; dime_in = 0; quarter_in = 0; cancel = 0;
        drink_sel = 4'b0; slot_empty = 4'b0; dispense_ack = 0;
        model_reset();
        @(negedge clk);
        compare_all();
        @(negedge clk);
        compare_all();
        reset = 1'b1;

        // Exact price, ack after 3 dispense cycles, no change
        drive(0, 0, 1, 0, 4'b0, 4'b0, 0);
        drive(0, 1, 0, 0, 4'b0, 4'b0, 0);
        drive(0, 0, 0, 0, 4'b0010, 4'b0, 0);
        idle(2);
        drive(0, 0, 0, 0, 4'b0, 4'b0, 1);
        idle(3);
        // Overpay by 3 nickels, change returned
        drive(0, 0, 1, 0, 4'b0, 4'b0, 0);
        drive(0, 0, 1, 0, 4'b0, 4'b0, 0);
        drive(0, 0, 0, 0, 4'b0001, 4'b0, 0);
        drive(0, 0, 0, 0, 4'b0, 4'b0, 1);
        idle(8);
        // Denials: short credit, not one-hot, empty slot; then cancel
        drive(0, 0, 1, 0, 4'b0, 4'b0, 0);
        drive(0, 0, 0, 0, 4'b1000, 4'b0, 0);
        drive(0, 0, 0, 0, 4'b0011, 4'b0, 0);
        drive(0, 1, 0, 0, 4'b0, 4'b0, 0);
        drive(0, 0, 0, 0, 4'b0100, 4'b0100, 0);
        drive(0, 0, 0, 1, 4'b0, 4'b0, 0);
        idle(16);
        // Dispense timeout with full refund
        drive(0, 0, 1, 0, 4'b0, 4'b0, 0);
        drive(0, 1, 0, 0, 4'b0, 4'b0, 0);
        drive(0, 0, 0, 0, 4'b0001, 4'b0, 0);
        idle(28);
        // Credit ceiling: 38 then rejections, then cancel
        for (int i = 0; i < 7; i++) drive(0, 0, 1, 0, 4'b0, 4'b0, 0);
        drive(0, 1, 0, 0, 4'b0, 4'b0, 0);
        drive(1, 0, 0, 0, 4'b0, 4'b0, 0);
        drive(0, 0, 1, 0, 4'b0, 4'b0, 0);
        drive(1, 1, 0, 0, 4'b0, 4'b0, 0);
        drive(1, 0, 0, 0, 4'b0, 4'b0, 0);
        drive(1, 0, 0, 0, 4'b0, 4'b0, 0);
        drive(0, 0, 0, 1, 4'b0, 4'b0, 0);
        idle(84);
        // Reset mid-change, then coin during dispense
        drive(0, 0, 1, 0, 4'b0, 4'b0, 0);
        drive(0, 0, 1, 0, 4'b0, 4'b0, 0);
        drive(0, 0, 0, 1, 4'b0, 4'b0, 0);
        idle(3);
        reset_pulse();
        idle(2);
        drive(0, 0, 1, 0, 4'b0, 4'b0, 0);
        drive(0, 0, 1, 0, 4'b0, 4'b0, 0);
        drive(0, 0, 0, 0, 4'b0001, 4'b0, 0);
        drive(0, 0, 1, 0, 4'b0, 4'b0, 0);
        drive(0, 0, 0, 0, 4'b0, 4'b0, 1);
        idle(10);

        // Biased random traffic
        for (int ph = 0; ph < 6; ph++) begin
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(299) == 0) begin
                    reset_pulse();
                end else begin
                    sel = 4'b0;
                    if ($urandom_range(99) < p_sel[ph]) begin
                        if ($urandom_range(3) != 0) sel = 4'b0001 << $urandom_range(3);
                        else sel = 4'($urandom_range(15, 1));
                    end
                    emp = 4'b0;
                    if ($urandom_range(99) < p_empty[ph]) emp = 4'b0001 << $urandom_range(3);
                    drive($urandom_range(99) < p_coin[ph] / 2,
                          $urandom_range(99) < p_coin[ph] / 2,
                          $urandom_range(99) < p_coin[ph] / 2,
                          $urandom_range(99) < p_cancel[ph],
                          sel, emp,
                          $urandom_range(99) < p_ack[ph]);
                end
            end
            idle(90);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
